// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Owns the PC, issues one-at-a-time requests to instruction memory over a
// ready/valid handshake, and drives the IF/ID register read by decode.
// A response that arrives while decode is stalled is parked in a one-entry
// buffer (HOLD) so nothing is lost or refetched. A taken branch from EX
// redirects the PC, bubbles IF/ID and discards any in-flight response.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   pc_enable       hazard unit: PC may advance
//   if_id_enable    hazard unit: IF/ID may load
//   branch_taken    EX: redirect this cycle
//   branch_target   EX: redirect address (low two bits ignored)
//   imem_req/addr   request valid / address (address is always pc)
//   imem_ready      memory accepts when imem_req && imem_ready
//   imem_rvalid     in-order response valid, one per accepted request
//   imem_rdata      response instruction
//   if_id_pc/inst/valid  IF/ID pipeline register
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_enable,
  input  logic            if_id_enable,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding on the bus this cycle
    S_WAIT  = 2'd1,  // request accepted, waiting for the response
    S_HOLD  = 2'd2   // response parked in buf_q until decode frees up
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } ifid_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic            discard_q, discard_n;
  logic [31:0]     buf_q, buf_n;
  ifid_t           ifid_q, ifid_n;

  logic            advance;
  logic            hs;
  logic            load_new;
  logic [31:0]     new_inst;
  ifid_t           bubble;

  // Fetch addresses are word aligned; the low target bits are dropped.
  logic            unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target[1:0];

  assign advance   = pc_enable && if_id_enable;
  // Request is a pure decode of registered state; held low while in reset
  // because the state register only settles on the first reset edge.
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = pc_q;
  assign hs        = imem_req && imem_ready;

  assign bubble.pc    = pc_q;
  assign bubble.inst  = NOP_INST;
  assign bubble.valid = 1'b0;

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    discard_n = discard_q;
    buf_n     = buf_q;
    ifid_n    = ifid_q;
    load_new  = 1'b0;
    new_inst  = NOP_INST;

    if (branch_taken) begin
      // Redirect wins over everything, including a stalled decode.
      pc_n   = {branch_target[XLEN-1:2], 2'b00};
      ifid_n = bubble;
      buf_n  = NOP_INST;
      case (state_q)
        S_FETCH: begin
          // Accepted this cycle: its response is stale, swallow it later.
          state_n   = hs ? S_WAIT : S_FETCH;
          discard_n = hs;
        end
        S_WAIT: begin
          // Response arriving now is dropped on the floor; otherwise keep
          // waiting for it and drop it when it shows up.
          state_n   = imem_rvalid ? S_FETCH : S_WAIT;
          discard_n = !imem_rvalid;
        end
        default: begin
          state_n   = S_FETCH;
          discard_n = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (hs) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_n = 1'b0;
              state_n   = S_FETCH;
            end else if (advance) begin
              load_new = 1'b1;
              new_inst = imem_rdata;
            end else begin
              buf_n   = imem_rdata;
              state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            load_new = 1'b1;
            new_inst = buf_q;
          end
        end
        default: state_n = S_FETCH;
      endcase

      if (load_new) begin
        ifid_n.pc    = pc_q;
        ifid_n.inst  = new_inst;
        ifid_n.valid = 1'b1;
        pc_n         = pc_q + XLEN'(4);
        state_n      = S_FETCH;
      end else if (if_id_enable) begin
        ifid_n = bubble;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      buf_q        <= NOP_INST;
      ifid_q.pc    <= '0;
      ifid_q.inst  <= NOP_INST;
      ifid_q.valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      discard_q <= discard_n;
      buf_q     <= buf_n;
      ifid_q    <= ifid_n;
    end
  end

  assign if_id_pc    = ifid_q.pc;
  assign if_id_inst  = ifid_q.inst;
  assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] N = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pe, ie, bt, rdy;
  logic [31:0] tgt;
  int          dly;

  logic        req, rvalid, ifv;
  logic [31:0] addr, rdata, ifpc, ifinst;

  // second instance for the PC wrap case
  logic        req2, rvalid2, ifv2;
  logic [31:0] addr2, rdata2, ifpc2, ifinst2;
  logic        one = 1'b1, zero = 1'b0;
  logic [31:0] zero32 = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_enable(pe), .if_id_enable(ie),
    .branch_taken(bt), .branch_target(tgt),
    .imem_req(req), .imem_addr(addr), .imem_ready(rdy),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .if_id_pc(ifpc), .if_id_inst(ifinst), .if_id_valid(ifv)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .pc_enable(one), .if_id_enable(one),
    .branch_taken(zero), .branch_target(zero32),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(one),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .if_id_pc(ifpc2), .if_id_inst(ifinst2), .if_id_valid(ifv2)
  );

  // Memory model: mem[i] = i, response after dly extra cycles.
  logic        pend;
  int          cnt;
  logic [31:0] pdata;
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0; rvalid <= 1'b0; rdata <= '0; cnt <= 0; pdata <= '0;
    end else begin
      rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 0) begin rvalid <= 1'b1; rdata <= pdata; pend <= 1'b0; end
        else cnt <= cnt - 1;
      end
      if (req && rdy) begin
        if (dly == 0) begin rvalid <= 1'b1; rdata <= addr >> 2; end
        else begin pend <= 1'b1; cnt <= dly - 1; pdata <= addr >> 2; end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin rvalid2 <= 1'b0; rdata2 <= '0; end
    else begin rvalid2 <= req2; rdata2 <= addr2 >> 2; end
  end

  typedef struct {
    logic        rst, pe, ie, bt;
    logic [31:0] tgt;
    logic        rdy;
    int          dly;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t v(logic r, logic p, logic i, logic b, logic [31:0] t,
                             logic rd, int d, logic q, logic [31:0] a,
                             logic vl, logic [31:0] pc, logic [31:0] in);
    vec_t x;
    x.rst = r; x.pe = p; x.ie = i; x.bt = b; x.tgt = t; x.rdy = rd; x.dly = d;
    x.req = q; x.addr = a; x.vld = vl; x.pc = pc; x.inst = in;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    //          rst pe ie bt tgt         rdy dly | req addr        vld pc          inst
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h000,0,32'h000,N));          // C0
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h000,N));          // C1
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h004,1,32'h000,32'd0));      // C2
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h004,N));          // C3
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h008,1,32'h004,32'd1));      // C4
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h008,N));          // C5
    vecs.push_back(v(0,0,0,0,0,1,0, 1,32'h00C,1,32'h008,32'd2));      // C6 stall
    vecs.push_back(v(0,0,0,0,0,1,0, 0,32'h000,1,32'h008,32'd2));      // C7 -> HOLD
    vecs.push_back(v(0,0,0,0,0,1,0, 0,32'h000,1,32'h008,32'd2));      // C8
    vecs.push_back(v(0,0,0,0,0,1,0, 0,32'h000,1,32'h008,32'd2));      // C9
    vecs.push_back(v(0,0,0,0,0,1,0, 0,32'h000,1,32'h008,32'd2));      // C10
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,1,32'h008,32'd2));      // C11 release
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h010,1,32'h00C,32'd3));      // C12
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h010,N));          // C13
    vecs.push_back(v(0,1,1,1,32'h100,1,0, 1,32'h014,1,32'h010,32'd4));// C14 br+hs
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h014,N));          // C15 drop
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h100,0,32'h100,N));          // C16
    vecs.push_back(v(0,1,1,1,32'h203,1,0, 0,32'h000,0,32'h100,N));    // C17 br+rvalid
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h200,0,32'h100,N));          // C18
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h200,N));          // C19
    vecs.push_back(v(0,1,1,0,0,0,0, 1,32'h204,1,32'h200,32'h80));     // C20 rdy=0
    vecs.push_back(v(0,1,1,0,0,0,0, 1,32'h204,0,32'h204,N));          // C21
    vecs.push_back(v(0,1,1,0,0,0,0, 1,32'h204,0,32'h204,N));          // C22
    vecs.push_back(v(0,1,1,0,0,0,0, 1,32'h204,0,32'h204,N));          // C23
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h204,0,32'h204,N));          // C24
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h204,N));          // C25
    vecs.push_back(v(0,1,1,0,0,1,2, 1,32'h208,1,32'h204,32'h81));     // C26 slow resp
    vecs.push_back(v(0,1,1,1,32'h300,1,0, 0,32'h000,0,32'h208,N));    // C27 br in WAIT
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h208,N));          // C28
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h300,N));          // C29 drop
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h300,0,32'h300,N));          // C30
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h300,N));          // C31
    vecs.push_back(v(0,0,0,0,0,1,0, 1,32'h304,1,32'h300,32'hC0));     // C32 stall
    vecs.push_back(v(0,0,0,0,0,1,0, 0,32'h000,1,32'h300,32'hC0));     // C33 -> HOLD
    vecs.push_back(v(0,0,0,1,32'h400,1,0, 0,32'h000,1,32'h300,32'hC0));// C34 br in HOLD
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h400,0,32'h304,N));          // C35
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h400,N));          // C36
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h404,1,32'h400,32'h100));    // C37
    vecs.push_back(v(1,1,1,0,0,1,0, 0,32'h000,0,32'h404,N));          // C38 rst in WAIT
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h000,0,32'h000,N));          // C39
    vecs.push_back(v(0,1,1,0,0,1,0, 0,32'h000,0,32'h000,N));          // C40
    vecs.push_back(v(0,1,1,0,0,1,0, 1,32'h004,1,32'h000,32'd0));      // C41

    rst = 1'b1; pe = 1'b1; ie = 1'b1; bt = 1'b0; tgt = '0; rdy = 1'b1; dly = 0;
    tick(); tick();
    // Still in reset with state already FETCH: request must stay low.
    chk("reset req", {31'd0, req}, 32'd0);
    chk("reset valid", {31'd0, ifv}, 32'd0);
    chk("reset inst", ifinst, N);
    chk("reset pc", ifpc, 32'd0);

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; pe = vecs[i].pe; ie = vecs[i].ie; bt = vecs[i].bt;
      tgt = vecs[i].tgt; rdy = vecs[i].rdy; dly = vecs[i].dly;
      #1;
      chk($sformatf("c%0d req", i), {31'd0, req}, {31'd0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("c%0d addr", i), addr, vecs[i].addr);
      chk($sformatf("c%0d valid", i), {31'd0, ifv}, {31'd0, vecs[i].vld});
      chk($sformatf("c%0d pc", i), ifpc, vecs[i].pc);
      chk($sformatf("c%0d inst", i), ifinst, vecs[i].inst);
      @(posedge clk); #1;
    end

    // PC wrap on the instance reset to 0xFFFF_FFFC.
    rst = 1'b1; pe = 1'b1; ie = 1'b1; bt = 1'b0; rdy = 1'b1; dly = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("wrap first req", {31'd0, req2}, 32'd1);
    chk("wrap first addr", addr2, 32'hFFFF_FFFC);
    tick(); tick(); #1;
    chk("wrap second req", {31'd0, req2}, 32'd1);
    chk("wrap second addr", addr2, 32'h0000_0000);
    chk("wrap ifid valid", {31'd0, ifv2}, 32'd1);
    chk("wrap ifid pc", ifpc2, 32'hFFFF_FFFC);
    chk("wrap ifid inst", ifinst2, 32'h3FFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
